// File: rtl/world_transition_ctrl.sv
// World (map) change sequencer: arbitrates game/button requests, fades to black, swaps map_en, waits for a frame, fades back in.
// Optional: define WORLDCTRL_CYCLE_EN to retarget same-map requests to the next map (wrapping 3->0).
module world_transition_ctrl #(
    parameter int FADE_STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_game,
    input  logic [1:0] sel_game,
    input  logic       req_btn,
    input  logic [1:0] sel_btn,
    input  logic       frame_start,
    output logic       ack_game,
    output logic       ack_btn,
    output logic [3:0] map_en,
    output logic [1:0] cur_map,
    output logic [3:0] fade_level,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FADE_OUT   = 3'd1,
        SWAP       = 3'd2,
        WAIT_FRAME = 3'd3,
        FADE_IN    = 3'd4
    } state_t;

    localparam logic [15:0] STEP_LAST = 16'(FADE_STEP_CYCLES - 1);

    state_t      state;
    logic [15:0] step_cnt;
    logic [1:0]  target;
    logic [1:0]  pick_sel;

    // Game logic has fixed priority over the buttons.
    assign pick_sel  = req_game ? sel_game : sel_btn;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            step_cnt   <= 16'd0;
            target     <= 2'd0;
            cur_map    <= 2'd0;
            map_en     <= 4'b0001;
            fade_level <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_game   <= 1'b0;
            ack_btn    <= 1'b0;
        end else begin
            ack_game <= 1'b0;
            ack_btn  <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_game) begin
                        ack_game <= 1'b1;
                    end else if (req_btn) begin
                        ack_btn <= 1'b1;
                    end
                    if (req_game || req_btn) begin
                        if (pick_sel != cur_map) begin
                            target     <= pick_sel;
                            state      <= FADE_OUT;
                            busy       <= 1'b1;
                            step_cnt   <= 16'd0;
                            fade_level <= 4'd0;
                        end
`ifdef WORLDCTRL_CYCLE_EN
                        else begin
                            target     <= cur_map + 2'd1;
                            state      <= FADE_OUT;
                            busy       <= 1'b1;
                            step_cnt   <= 16'd0;
                            fade_level <= 4'd0;
                        end
`endif
                    end
                end
                FADE_OUT: begin
                    // Level 15 is held for a full step before leaving, so the fade spans 16 steps.
                    if (step_cnt == STEP_LAST) begin
                        step_cnt <= 16'd0;
                        if (fade_level == 4'd15) begin
                            state <= SWAP;
                        end else begin
                            fade_level <= fade_level + 4'd1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 16'd1;
                    end
                end
                SWAP: begin
                    cur_map  <= target;
                    map_en   <= 4'b0001 << target;
                    state    <= WAIT_FRAME;
                    step_cnt <= 16'd0;
                end
                WAIT_FRAME: begin
                    if (frame_start) begin
                        state    <= FADE_IN;
                        step_cnt <= 16'd0;
                    end
                end
                FADE_IN: begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt <= 16'd0;
                        if (fade_level == 4'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            fade_level <= fade_level - 4'd1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    step_cnt <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_world_transition_ctrl.sv
// Directed bench for world_transition_ctrl with FADE_STEP_CYCLES = 4.
`timescale 1ns/1ps
module tb_world_transition_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FADE_OUT = 3'd1;
  localparam logic [2:0] ST_SWAP = 3'd2;
  localparam logic [2:0] ST_WAIT_FRAME = 3'd3;
  localparam logic [2:0] ST_FADE_IN = 3'd4;

  logic clk;
  logic reset;
  logic req_game;
  logic [1:0] sel_game;
  logic req_btn;
  logic [1:0] sel_btn;
  logic frame_start;
  logic frame_gen;
  logic frame_manual;
  logic frame_gen_en;
  logic ack_game;
  logic ack_btn;
  logic [3:0] map_en;
  logic [1:0] cur_map;
  logic [3:0] fade_level;
  logic busy;
  logic done;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;

  assign frame_start = frame_gen | frame_manual;

  world_transition_ctrl #(.FADE_STEP_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_game(req_game), .sel_game(sel_game),
    .req_btn(req_btn), .sel_btn(sel_btn),
    .frame_start(frame_start),
    .ack_game(ack_game), .ack_btn(ack_btn),
    .map_en(map_en), .cur_map(cur_map), .fade_level(fade_level),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // frame_start generator: one-cycle pulse every 100 cycles while enabled
  initial begin
    int fcnt;
    fcnt = 0;
    frame_gen = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_gen_en) begin
        fcnt = (fcnt + 1) % 100;
        frame_gen = (fcnt == 99);
      end else begin
        fcnt = 0;
        frame_gen = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_dbg === st) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Advances until done is seen; counts ack pulses observed on the way.
  task automatic wait_done(input int budget, output bit hit, output int acks);
    hit = 1'b0;
    acks = 0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        hit = 1'b1;
        break;
      end
      if (ack_game === 1'b1 || ack_btn === 1'b1) acks++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bit hit;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    checks++;
    if (map_en !== 4'b0001 || cur_map !== 2'd0 || fade_level !== 4'd0) begin
      failures++;
      $display("FAIL reset_values map_en=%b cur_map=%0d fade=%0d exp 0001/0/0", map_en, cur_map, fade_level);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ack_game !== 1'b0 || ack_btn !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b ackg=%b ackb=%b st=%0d exp all 0", busy, done, ack_game, ack_btn, state_dbg);
    end
    // reset mid FADE_OUT at fade_level 7
    req_btn = 1'b1;
    sel_btn = 2'd2;
    cyc(1);
    req_btn = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (fade_level === 4'd7) begin
        hit = 1'b1;
        break;
      end
      cyc(1);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL reset_reach_fade7 fade=%0d exp 7", fade_level);
    end
    reset = 1'b1;
    cyc(1);
    checks++;
    if (map_en !== 4'b0001 || cur_map !== 2'd0 || fade_level !== 4'd0 || busy !== 1'b0 ||
        done !== 1'b0 || ack_game !== 1'b0 || ack_btn !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_mid_fade map_en=%b cur=%0d fade=%0d busy=%b done=%b st=%0d exp 0001/0/0/0/0/0",
               map_en, cur_map, fade_level, busy, done, state_dbg);
    end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_basic;
    bit hit;
    int acks;
    int bad;
    frame_gen_en = 1'b1;
    req_btn = 1'b1;
    sel_btn = 2'd2;
    cyc(1);
    req_btn = 1'b0;
    checks++;
    if (ack_btn !== 1'b1 || busy !== 1'b1 || state_dbg !== ST_FADE_OUT || ack_game !== 1'b0) begin
      failures++;
      $display("FAIL basic_accept ackb=%b busy=%b st=%0d ackg=%b exp 1/1/1/0", ack_btn, busy, state_dbg, ack_game);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (fade_level !== 4'(i / 4) || map_en !== 4'b0001 || ack_btn !== (i == 0)) begin
        if (bad == 0)
          $display("FAIL basic_fade_out cycle=%0d fade=%0d exp %0d map_en=%b ackb=%b", i, fade_level, i / 4, map_en, ack_btn);
        bad++;
      end
      cyc(1);
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (state_dbg !== ST_SWAP || map_en !== 4'b0001 || fade_level !== 4'd15) begin
      failures++;
      $display("FAIL basic_swap st=%0d map_en=%b fade=%0d exp 2/0001/15", state_dbg, map_en, fade_level);
    end
    cyc(1);
    checks++;
    if (map_en !== 4'b0100 || cur_map !== 2'd2 || fade_level !== 4'd15) begin
      failures++;
      $display("FAIL basic_map_swapped map_en=%b cur=%0d fade=%0d exp 0100/2/15", map_en, cur_map, fade_level);
    end
    wait_state(ST_FADE_IN, 150, hit);
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL basic_wait_frame st=%0d exp 4", state_dbg);
    end
    bad = 0;
    for (int j = 0; j < 64; j++) begin
      if (fade_level !== 4'(15 - j / 4) || done !== 1'b0 || busy !== 1'b1) begin
        if (bad == 0)
          $display("FAIL basic_fade_in cycle=%0d fade=%0d exp %0d done=%b busy=%b", j, fade_level, 15 - j / 4, done, busy);
        bad++;
      end
      cyc(1);
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || fade_level !== 4'd0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL basic_done done=%b busy=%b fade=%0d st=%0d exp 1/0/0/0", done, busy, fade_level, state_dbg);
    end
    cyc(1);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse done=%b exp 0", done);
    end
    wait_done(10, hit, acks);
  endtask

  task automatic test_arbitration;
    bit hit;
    int acks;
    req_game = 1'b1;
    sel_game = 2'd3;
    req_btn = 1'b1;
    sel_btn = 2'd1;
    cyc(1);
    req_game = 1'b0;
    checks++;
    if (ack_game !== 1'b1 || ack_btn !== 1'b0) begin
      failures++;
      $display("FAIL arb_ack ackg=%b ackb=%b exp 1/0", ack_game, ack_btn);
    end
    cyc(1);
    wait_done(400, hit, acks);
    checks++;
    if (!hit || acks != 0 || map_en !== 4'b1000 || cur_map !== 2'd3) begin
      failures++;
      $display("FAIL arb_result done_seen=%b acks=%0d map_en=%b cur=%0d exp 1/0/1000/3", hit, acks, map_en, cur_map);
    end
    cyc(1);
    req_btn = 1'b0;
    checks++;
    if (ack_btn !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL arb_held_btn ackb=%b busy=%b exp 1/1", ack_btn, busy);
    end
    cyc(1);
    wait_done(400, hit, acks);
    checks++;
    if (!hit || map_en !== 4'b0010 || cur_map !== 2'd1) begin
      failures++;
      $display("FAIL arb_btn_result done_seen=%b map_en=%b cur=%0d exp 1/0010/1", hit, map_en, cur_map);
    end
    cyc(1);
  endtask

  task automatic test_busy_drop;
    bit hit;
    int acks;
    int bad;
    req_btn = 1'b1;
    sel_btn = 2'd0;
    cyc(1);
    req_btn = 1'b0;
    wait_state(ST_FADE_IN, 400, hit);
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL drop_reach_fade_in st=%0d exp 4", state_dbg);
    end
    req_btn = 1'b1;
    sel_btn = 2'd3;
    cyc(1);
    req_btn = 1'b0;
    checks++;
    if (ack_btn !== 1'b0) begin
      failures++;
      $display("FAIL drop_no_ack ackb=%b exp 0", ack_btn);
    end
    wait_done(200, hit, acks);
    checks++;
    if (!hit || acks != 0 || map_en !== 4'b0001) begin
      failures++;
      $display("FAIL drop_done done_seen=%b acks=%0d map_en=%b exp 1/0/0001", hit, acks, map_en);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (busy !== 1'b0 || ack_btn !== 1'b0 || map_en !== 4'b0001) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL drop_no_followup bad_cycles=%0d exp 0", bad);
    end
  endtask

  task automatic test_same_map;
    bit hit;
    int acks;
    int bad;
    req_game = 1'b1;
    sel_game = 2'd3;
    cyc(1);
    req_game = 1'b0;
    cyc(1);
    wait_done(400, hit, acks);
    cyc(1);
    checks++;
    if (!hit || map_en !== 4'b1000 || cur_map !== 2'd3) begin
      failures++;
      $display("FAIL same_setup done_seen=%b map_en=%b cur=%0d exp 1/1000/3", hit, map_en, cur_map);
    end
    req_game = 1'b1;
    sel_game = 2'd3;
    cyc(1);
    req_game = 1'b0;
`ifdef WORLDCTRL_CYCLE_EN
    checks++;
    if (ack_game !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL same_ack ackg=%b busy=%b exp 1/1", ack_game, busy);
    end
    cyc(1);
    wait_done(400, hit, acks);
    checks++;
    if (!hit || map_en !== 4'b0001 || cur_map !== 2'd0) begin
      failures++;
      $display("FAIL same_cycle done_seen=%b map_en=%b cur=%0d exp 1/0001/0", hit, map_en, cur_map);
    end
    cyc(1);
`else
    checks++;
    if (ack_game !== 1'b1 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL same_ack ackg=%b busy=%b st=%0d exp 1/0/0", ack_game, busy, state_dbg);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (busy !== 1'b0 || done !== 1'b0 || ack_game !== 1'b0 || map_en !== 4'b1000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL same_ignored bad_cycles=%0d exp 0", bad);
    end
`endif
  endtask

  task automatic test_frame_in_swap;
    bit hit;
    int acks;
    int bad;
    frame_gen_en = 1'b0;
    cyc(2);
    req_btn = 1'b1;
    sel_btn = 2'd2;
    cyc(1);
    req_btn = 1'b0;
    wait_state(ST_SWAP, 100, hit);
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL swap_reach st=%0d exp 2", state_dbg);
    end
    frame_manual = 1'b1;
    cyc(1);
    frame_manual = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (state_dbg !== ST_WAIT_FRAME || fade_level !== 4'd15) bad++;
      cyc(1);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL swap_pulse_ignored bad_cycles=%0d st=%0d fade=%0d exp 3/15", bad, state_dbg, fade_level);
    end
    frame_manual = 1'b1;
    cyc(1);
    frame_manual = 1'b0;
    checks++;
    if (state_dbg !== ST_FADE_IN || fade_level !== 4'd15) begin
      failures++;
      $display("FAIL swap_next_pulse st=%0d fade=%0d exp 4/15", state_dbg, fade_level);
    end
    wait_done(200, hit, acks);
    checks++;
    if (!hit || map_en !== 4'b0100) begin
      failures++;
      $display("FAIL swap_final done_seen=%b map_en=%b exp 1/0100", hit, map_en);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_game = 1'b0;
    sel_game = 2'd0;
    req_btn = 1'b0;
    sel_btn = 2'd0;
    frame_manual = 1'b0;
    frame_gen_en = 1'b0;
    test_reset();
    test_basic();
    test_arbitration();
    test_busy_drop();
    test_same_map();
    test_frame_in_swap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
